// File: rtl/sap_control_sequencer.sv
// ---------------------------------------------------------------------------
// sap_control_sequencer
//
// Control sequencer for the 8-bit SAP CPU.
// Every instruction is stepped through a fixed six-T-state ring (T1..T6).
// T1..T3 fetch the instruction and are identical for all opcodes.
// T4..T6 execute it, decoded from the opcode and the carry/zero flags.
// An HLT instruction parks the machine in a HALT state until reset.
//
// Ports
//   clk      in   system clock; all state changes on the rising edge
//   rst_n    in   synchronous active-low reset; forces next state to T1
//   opcode   in   IR[7:4]; must be stable from T4 through T6
//   flag_c   in   carry flag (JC condition, sampled during T4)
//   flag_z   in   zero flag  (JZ condition, sampled during T4)
//   cp       out  PC increment
//   ep       out  PC drives bus
//   lp       out  PC load from bus
//   lm       out  MAR load
//   ce       out  RAM drives bus
//   li       out  IR load
//   ei       out  IR operand drives bus
//   la       out  A register load
//   ea       out  A register drives bus
//   lb       out  B register load
//   su       out  ALU subtract select
//   eu       out  ALU drives bus
//   lo       out  output register load
//   hlt      out  halted indicator / clock-gate request
//   t_state  out  current T-state 1..6, 0 when halted
// ---------------------------------------------------------------------------
module sap_control_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic       cp,
    output logic       ep,
    output logic       lp,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       lb,
    output logic       su,
    output logic       eu,
    output logic       lo,
    output logic       hlt,
    output logic [2:0] t_state
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_JC  = 4'b0100;
    localparam logic [3:0] OP_JZ  = 4'b0101;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // One-hot ring T1..T6 plus a dedicated HALT bit.
    typedef enum logic [6:0] {
        ST_T1   = 7'b0000001,
        ST_T2   = 7'b0000010,
        ST_T3   = 7'b0000100,
        ST_T4   = 7'b0001000,
        ST_T5   = 7'b0010000,
        ST_T6   = 7'b0100000,
        ST_HALT = 7'b1000000
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Reset wins over everything, including HALT and a half-finished instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_T1;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_T1;
        unique case (r_state)
            ST_T1:   w_next_state = ST_T2;
            ST_T2:   w_next_state = ST_T3;
            ST_T3:   w_next_state = ST_T4;
            // HLT leaves the ring right after its (strobe-free) T4.
            ST_T4:   w_next_state = (opcode == OP_HLT) ? ST_HALT : ST_T5;
            ST_T5:   w_next_state = ST_T6;
            ST_T6:   w_next_state = ST_T1;
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_T1;
        endcase
    end

    // Control word decode. Strobes are gated by rst_n so nothing is
    // issued to the datapath while reset is held, whatever the state.
    always_comb begin
        cp      = 1'b0;
        ep      = 1'b0;
        lp      = 1'b0;
        lm      = 1'b0;
        ce      = 1'b0;
        li      = 1'b0;
        ei      = 1'b0;
        la      = 1'b0;
        ea      = 1'b0;
        lb      = 1'b0;
        su      = 1'b0;
        eu      = 1'b0;
        lo      = 1'b0;
        hlt     = 1'b0;
        t_state = 3'd0;

        unique case (r_state)
            ST_T1:   t_state = 3'd1;
            ST_T2:   t_state = 3'd2;
            ST_T3:   t_state = 3'd3;
            ST_T4:   t_state = 3'd4;
            ST_T5:   t_state = 3'd5;
            ST_T6:   t_state = 3'd6;
            default: t_state = 3'd0;
        endcase

        if (rst_n) begin
            unique case (r_state)
                ST_T1: begin
                    ep = 1'b1;
                    lm = 1'b1;
                end
                ST_T2: begin
                    cp = 1'b1;
                end
                ST_T3: begin
                    ce = 1'b1;
                    li = 1'b1;
                end
                ST_T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ei = 1'b1;
                            lm = 1'b1;
                        end
                        OP_JMP: begin
                            ei = 1'b1;
                            lp = 1'b1;
                        end
                        // Conditional jumps look at the flags only here, in T4.
                        OP_JC: begin
                            ei = flag_c;
                            lp = flag_c;
                        end
                        OP_JZ: begin
                            ei = flag_z;
                            lp = flag_z;
                        end
                        OP_OUT: begin
                            ea = 1'b1;
                            lo = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_T5: begin
                    case (opcode)
                        OP_LDA: begin
                            ce = 1'b1;
                            la = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ce = 1'b1;
                            lb = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_T6: begin
                    case (opcode)
                        OP_ADD: begin
                            eu = 1'b1;
                            la = 1'b1;
                        end
                        OP_SUB: begin
                            su = 1'b1;
                            eu = 1'b1;
                            la = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_HALT: begin
                    hlt = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
module tb_sap_control_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       flag_c;
    logic       flag_z;
    logic       cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo, hlt;
    logic [2:0] t_state;

    sap_control_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .flag_c  (flag_c),
        .flag_z  (flag_z),
        .cp      (cp),
        .ep      (ep),
        .lp      (lp),
        .lm      (lm),
        .ce      (ce),
        .li      (li),
        .ei      (ei),
        .la      (la),
        .ea      (ea),
        .lb      (lb),
        .su      (su),
        .eu      (eu),
        .lo      (lo),
        .hlt     (hlt),
        .t_state (t_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit positions of the control word as the bench packs it.
    localparam int B_CP = 13, B_EP = 12, B_LP = 11, B_LM = 10, B_CE = 9, B_LI = 8, B_EI = 7;
    localparam int B_LA = 6, B_EA = 5, B_LB = 4, B_SU = 3, B_EU = 2, B_LO = 1, B_HLT = 0;

    int n_vec;
    int n_err;
    int m_t;          // reference model: current T-state number, 0 = halted
    int halt_cycles;

    function automatic logic [13:0] dut_word();
        return {cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo, hlt};
    endfunction

    // Expected control word, straight from the instruction tables.
    function automatic logic [13:0] exp_word(int t, logic [3:0] op, logic fc, logic fz, logic rstn);
        logic [13:0] w;
        w = '0;
        if (!rstn) return w;
        if (t == 0) w[B_HLT] = 1'b1;
        if (t == 1) begin w[B_EP] = 1'b1; w[B_LM] = 1'b1; end
        if (t == 2) w[B_CP] = 1'b1;
        if (t == 3) begin w[B_CE] = 1'b1; w[B_LI] = 1'b1; end
        if (t == 4) begin
            if (op <= 4'd2)                 begin w[B_EI] = 1'b1; w[B_LM] = 1'b1; end
            if (op == 4'd3)                 begin w[B_EI] = 1'b1; w[B_LP] = 1'b1; end
            if (op == 4'd4 && fc)           begin w[B_EI] = 1'b1; w[B_LP] = 1'b1; end
            if (op == 4'd5 && fz)           begin w[B_EI] = 1'b1; w[B_LP] = 1'b1; end
            if (op == 4'd14)                begin w[B_EA] = 1'b1; w[B_LO] = 1'b1; end
        end
        if (t == 5) begin
            if (op == 4'd0)                 begin w[B_CE] = 1'b1; w[B_LA] = 1'b1; end
            if (op == 4'd1 || op == 4'd2)   begin w[B_CE] = 1'b1; w[B_LB] = 1'b1; end
        end
        if (t == 6) begin
            if (op == 4'd1)                 begin w[B_EU] = 1'b1; w[B_LA] = 1'b1; end
            if (op == 4'd2)                 begin w[B_SU] = 1'b1; w[B_EU] = 1'b1; w[B_LA] = 1'b1; end
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0d op=%h)", tag, obs, exp, m_t, opcode);
        end
    endtask

    // One clock cycle: drive on the falling edge, check mid-cycle, then
    // advance the reference model on the rising edge with the same inputs.
    task automatic step(input logic [3:0] op, input logic fc, input logic fz, input logic rstn);
        @(negedge clk);
        opcode = op;
        flag_c = fc;
        flag_z = fz;
        rst_n  = rstn;
        #1;
        chk("ctrl", {2'b00, dut_word()}, {2'b00, exp_word(m_t, op, fc, fz, rstn)});
        chk("tstate", {13'd0, t_state}, 16'(m_t));
        chk("cp_lp", {15'd0, cp & lp}, 16'd0);
        chk("bus1", {15'd0, ($countones({ep, ce, ei, ea, eu}) > 1)}, 16'd0);
        @(posedge clk);
        if (!rstn)                          m_t = 1;
        else if (m_t == 0)                  m_t = 0;
        else if (m_t == 4 && op == 4'hF)    m_t = 0;
        else if (m_t == 6)                  m_t = 1;
        else                                m_t = m_t + 1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic fc, input logic fz);
        for (int i = 0; i < 6; i++) step(op, fc, fz, 1'b1);
        $display("instr op=%h c=%0d z=%0d done, t=%0d, miscompares so far %0d", op, fc, fz, m_t, n_err);
    endtask

    logic [3:0] r_op;
    logic       r_rst;

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        opcode = 4'h0;
        flag_c = 1'b0;
        flag_z = 1'b0;
        @(posedge clk);
        m_t = 1;

        // Reset held two cycles, then fetch/ADD.
        step(4'h1, 1'b0, 1'b0, 1'b0);
        step(4'h1, 1'b0, 1'b0, 1'b0);
        $display("reset held 2 cycles, t=%0d", m_t);
        run_instr(4'h1, 1'b0, 1'b0);   // ADD
        run_instr(4'h4, 1'b0, 1'b1);   // JC not taken
        run_instr(4'h4, 1'b1, 1'b0);   // JC taken
        run_instr(4'h5, 1'b0, 1'b1);   // JZ taken
        run_instr(4'h0, 1'b1, 1'b1);   // LDA
        run_instr(4'hE, 1'b0, 1'b0);   // OUT
        run_instr(4'h3, 1'b0, 1'b0);   // JMP
        run_instr(4'h7, 1'b1, 1'b1);   // NOP

        // SUB interrupted by reset in T5.
        for (int i = 0; i < 4; i++) step(4'h2, 1'b0, 1'b0, 1'b1);
        step(4'h2, 1'b0, 1'b0, 1'b0);
        chk("sub_rst_t1", 16'(m_t), 16'd1);
        $display("SUB reset in T5, t=%0d", m_t);
        run_instr(4'h2, 1'b0, 1'b0);

        // HLT then parked for 12 cycles, then a 1-cycle reset pulse.
        for (int i = 0; i < 4; i++) step(4'hF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(4'hF, i[0], i[1], 1'b1);
        end
        chk("halt_hold", {15'd0, hlt}, 16'd1);
        step(4'hF, 1'b0, 1'b0, 1'b0);
        $display("HLT parked and reset, t=%0d", m_t);
        run_instr(4'h1, 1'b0, 1'b0);

        // Random opcode/flag stream; opcode only changes at the start of fetch.
        r_op = 4'($urandom_range(0, 15));
        halt_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            if (m_t == 1) r_op = 4'($urandom_range(0, 15));
            if (m_t == 0) begin
                halt_cycles++;
                r_rst = ($urandom_range(0, 7) != 0);
            end else begin
                r_rst = ($urandom_range(0, 199) != 0);
            end
            step(r_op, 1'($urandom), 1'($urandom), r_rst);
        end
        $display("random stream 1000 cycles, %0d halted cycles", halt_cycles);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Control sequencer for the 8-bit CPU: issues the control word that drives the program counter (increment, bus-enable, load) and every other bus participant, stepping each instruction through a fixed six-T-state ring. It is the initiator side of the program-counter control interface and sits between the instruction register/flags and all datapath blocks. Instruction format is `[7:4]` opcode, `[3:0]` address operand. Address bus is 4 bits.

## Interface
Parameters: none. Opcode encodings are fixed (see Operation).

Ports:
- `clk` in 1 — single system clock; all state changes on rising edge.
- `rst_n` in 1 — reset, synchronous, active-low.
- `opcode` in 4 — instruction register bits `[7:4]`; must be stable from T4 through T6.
- `flag_c` in 1 — carry flag.
- `flag_z` in 1 — zero flag.
- `cp` out 1 — PC increment.
- `ep` out 1 — PC drives bus.
- `lp` out 1 — PC load from bus (jump).
- `lm` out 1 — MAR load.
- `ce` out 1 — RAM drives bus.
- `li` out 1 — IR load.
- `ei` out 1 — IR operand drives bus.
- `la` out 1 — A register load.
- `ea` out 1 — A register drives bus.
- `lb` out 1 — B register load.
- `su` out 1 — ALU subtract select.
- `eu` out 1 — ALU drives bus.
- `lo` out 1 — output register load.
- `hlt` out 1 — halted indicator / clock-gate request.
- `t_state` out 3 — current T-state, 1..6; 0 when halted.

## Operation
- State register holds a one-hot ring T1→T2→T3→T4→T5→T6→T1, plus a HALT state.
- Control outputs are a combinational decode of state, `opcode`, and flags. Only the signals listed below are 1; all others are 0.
- Fetch, identical for every opcode:
  - T1: `ep`, `lm`.
  - T2: `cp`.
  - T3: `ce`, `li`.
- Execute phase:
  - 0000 LDA: T4 `ei lm`; T5 `ce la`; T6 none.
  - 0001 ADD: T4 `ei lm`; T5 `ce lb`; T6 `eu la`.
  - 0010 SUB: T4 `ei lm`; T5 `ce lb`; T6 `su eu la`.
  - 0011 JMP: T4 `ei lp`; T5/T6 none.
  - 0100 JC: T4 `ei lp` only if `flag_c`=1, else none; T5/T6 none.
  - 0101 JZ: same as JC, gated by `flag_z`.
  - 1110 OUT: T4 `ea lo`; T5/T6 none.
  - 1111 HLT: T4 asserts no control strobes; next edge enters HALT.
  - All other opcodes are NOP: T4–T6 none.
- HALT:
  - `hlt`=1, all other outputs 0, `t_state`=0.
  - Remains in HALT until `rst_n`=0.
- Invariants:
  - `cp` and `lp` are never 1 in the same cycle.
  - At most one bus driver (`ep`, `ce`, `ei`, `ea`, `eu`) is 1 in any cycle.
- Jump flags are sampled combinationally during T4 only.

## Timing
- Reset:
  - With `rst_n`=0 at a rising edge, the next state is T1 regardless of the current state, including HALT or mid-instruction.
  - While `rst_n`=0, all control outputs and `hlt` are forced to 0. `t_state` reads 1 once the reset edge has occurred.
- After reset release, the first cycle is T1 (`ep`=`lm`=1).
- Every instruction takes exactly 6 cycles, including jumps and NOPs. There is no early ring termination.
- HLT: T4 is the last active cycle; `hlt`=1 from the following cycle onward.
- Outputs change only as a result of a state change (clock edge), or of an `opcode`/flag change within a state. Datapath blocks sample strobes on the next rising edge.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles, then release.
  - Required: cycle 1 `t_state`=1 with `ep lm`; cycle 2 `cp`; cycle 3 `ce li`.
- ADD (opcode 0001), T4–T6 in order.
  - Required: T4 `ei lm`; T5 `ce lb`; T6 `eu la`, `su`=0.
  - Next cycle is T1.
- JC with `flag_c`=0, then `flag_c`=1.
  - Required: T4 has no strobes in the first case; T4 has `ei lp`=1 in the second.
  - Both cases return to T1 after T6.
- HLT (opcode 1111).
  - Required: T4 has no strobes; from the next cycle `hlt`=1 and `t_state`=0 for 10+ cycles.
  - After a 1-cycle `rst_n`=0 pulse, T1 resumes.
- Reset mid-instruction: assert `rst_n`=0 during T5 of SUB.
  - Required: all outputs 0 while in reset; next state T1; no `la` pulse is issued.
- Invariant check over a random opcode/flag stream of 1000 cycles.
  - Required: never `cp`&`lp`; at most one bus driver high per cycle.
